spm_mem_loader: RTL and testbench

SPM_MEM_LOADER -- requirements
Module: spm_mem_loader

---
 rtl/spm_pkg.sv | 14 +
 rtl/spm_sync_edge.sv | 28 ++
 rtl/spm_mem_loader.sv | 209 ++++++++++++++++++++
 tb/tb_spm_mem_loader.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spm_pkg.sv
// Shared definitions for the scratch-pad memory loader: FSM encoding and pad
// output-enable idle level.
package spm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DUMP = 2'd2
  } spm_state_e;

  // Pads are inputs (output drivers off) whenever the loader is not dumping.
  localparam logic IO_OEB_RESET = 1'b1;

endpackage

// File: rtl/spm_sync_edge.sv
// Two-flop synchroniser for an asynchronous pad strobe, followed by a
// rising-edge detector on the synchronised level.
module spm_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/spm_mem_loader.sv
// Scratch-pad memory shared by a core port and a pad-side loader/dumper.
// Optional even-parity storage is enabled by defining SPM_MEM_PARITY_EN.
module spm_mem_loader
  import spm_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int DUMP_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ext_write,
  input  logic              ext_dump,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] mem_out,
  output logic              mem_strb,
  output logic [DATA_W-1:0] io_oeb,
  output logic              addr_err,
  output logic              parity_err,
  output spm_state_e        fsm_state
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DIV_W = $clog2(DUMP_DIV);
  localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [DIV_W-1:0] LAST_DIV  = DIV_W'(DUMP_DIV - 1);
`ifdef SPM_MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  logic [MEM_W-1:0] mem [DEPTH];

  spm_state_e        state_q;
  logic [DATA_W-1:0] pad_data_q;
  logic [ADDR_W-1:0] pad_addr_q;
  logic [IDX_W-1:0]  word_q;
  logic [DIV_W-1:0]  div_q;
  logic [DATA_W-1:0] mem_out_q;
  logic              strb_q;
  logic [DATA_W-1:0] oeb_q;
  logic              stall_q;
  logic              addr_err_q;
  logic [DATA_W-1:0] rdata_q;

  logic write_rise;
  logic dump_rise;

  spm_sync_edge u_sync_write (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (ext_write),
    .rise_o  (write_rise)
  );

  spm_sync_edge u_sync_dump (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (ext_dump),
    .rise_o  (dump_rise)
  );

  // Core port contract: while cpu_stall is high the pad side owns the array,
  // core writes are dropped and the core must hold its request.
  logic             pad_in_range;
  logic             cpu_in_range;
  logic             pad_we;
  logic             core_we;
  logic [MEM_W-1:0] pad_word;
  logic [MEM_W-1:0] core_word;
  logic [MEM_W-1:0] rd_word;
  logic [IDX_W-1:0] word_nxt;
  logic [IDX_W-1:0] dump_idx;
  logic [MEM_W-1:0] dump_word;

  assign pad_in_range = ({1'b0, pad_addr_q} < DEPTH_LIM);
  assign cpu_in_range = ({1'b0, cpu_addr} < DEPTH_LIM);
  assign pad_we       = (state_q == ST_LOAD) && pad_in_range;
  assign core_we      = cpu_we && !stall_q && cpu_in_range;
  assign word_nxt     = word_q + 1'b1;
  assign dump_idx     = (state_q == ST_DUMP) ? word_nxt : '0;
  assign dump_word    = mem[dump_idx];
  assign rd_word      = mem[cpu_addr[IDX_W-1:0]];

`ifdef SPM_MEM_PARITY_EN
  assign pad_word  = {^pad_data_q, pad_data_q};
  assign core_word = {^cpu_wdata, cpu_wdata};
`else
  assign pad_word  = pad_data_q;
  assign core_word = cpu_wdata;
`endif

  // Array is deliberately left out of reset so contents survive an abort.
  always_ff @(posedge clk) begin
    if (pad_we) begin
      mem[pad_addr_q[IDX_W-1:0]] <= pad_word;
    end else if (core_we) begin
      mem[cpu_addr[IDX_W-1:0]] <= core_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (cpu_in_range) begin
      rdata_q <= rd_word[DATA_W-1:0];
    end else begin
      rdata_q <= '0;
    end
  end

`ifdef SPM_MEM_PARITY_EN
  logic parity_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_q <= 1'b0;
    end else if (cpu_in_range && (^rd_word)) begin
      parity_err_q <= 1'b1;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pad_data_q <= '0;
      pad_addr_q <= '0;
      word_q     <= '0;
      div_q      <= '0;
      mem_out_q  <= '0;
      strb_q     <= 1'b0;
      oeb_q      <= {DATA_W{IO_OEB_RESET}};
      stall_q    <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A load edge always wins over a simultaneous dump edge.
          if (write_rise) begin
            pad_data_q <= data_in;
            pad_addr_q <= addr_in;
            stall_q    <= 1'b1;
            state_q    <= ST_LOAD;
          end else if (dump_rise) begin
            word_q    <= '0;
            div_q     <= '0;
            mem_out_q <= dump_word[DATA_W-1:0];
            strb_q    <= ~strb_q;
            oeb_q     <= '0;
            stall_q   <= 1'b1;
            state_q   <= ST_DUMP;
          end
        end
        ST_LOAD: begin
          if (!pad_in_range) begin
            addr_err_q <= 1'b1;
          end
          stall_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        ST_DUMP: begin
          if (div_q == LAST_DIV) begin
            div_q <= '0;
            if (word_q == LAST_IDX) begin
              word_q    <= '0;
              mem_out_q <= '0;
              oeb_q     <= {DATA_W{IO_OEB_RESET}};
              stall_q   <= 1'b0;
              state_q   <= ST_IDLE;
            end else begin
              word_q    <= word_nxt;
              mem_out_q <= dump_word[DATA_W-1:0];
              strb_q    <= ~strb_q;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        default: begin
          stall_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_stall = stall_q;
  assign mem_out   = mem_out_q;
  assign mem_strb  = strb_q;
  assign io_oeb    = oeb_q;
  assign addr_err  = addr_err_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_spm_mem_loader.sv
// Self-checking bench for spm_mem_loader: a default 256-word instance plus a
// 16-word instance for out-of-range pad and core accesses.
module tb_spm_mem_loader;
  import spm_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, ext_write, ext_dump, cpu_we;
  logic [7:0] data_in, addr_in, cpu_addr, cpu_wdata;
  logic [7:0] cpu_rdata, mem_out, io_oeb;
  logic       cpu_stall, mem_strb, addr_err, parity_err;
  spm_state_e fsm_state;

  logic       w16, dp16, cwe16;
  logic [7:0] d16, a16, ca16, cwd16;
  logic [7:0] rd16, mo16, oeb16;
  logic       st16, ms16, ae16, pe16;
  spm_state_e fs16;

  spm_mem_loader dut (
    .clk(clk), .rst_n(rst_n), .ext_write(ext_write), .ext_dump(ext_dump),
    .data_in(data_in), .addr_in(addr_in), .cpu_addr(cpu_addr), .cpu_we(cpu_we),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_out(mem_out), .mem_strb(mem_strb), .io_oeb(io_oeb),
    .addr_err(addr_err), .parity_err(parity_err), .fsm_state(fsm_state)
  );

  spm_mem_loader #(.DEPTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .ext_write(w16), .ext_dump(dp16),
    .data_in(d16), .addr_in(a16), .cpu_addr(ca16), .cpu_we(cwe16),
    .cpu_wdata(cwd16), .cpu_rdata(rd16), .cpu_stall(st16),
    .mem_out(mo16), .mem_strb(ms16), .io_oeb(oeb16),
    .addr_err(ae16), .parity_err(pe16), .fsm_state(fs16)
  );

  logic [7:0] exp_q[$];
  logic [7:0] model_mem [256];
  logic [7:0] model16 [16];
  int checks = 0;
  int errors = 0;

  task automatic drive_read(input logic [7:0] a);
    @(negedge clk);
    cpu_we = 1'b0; cpu_addr = a;
    exp_q.push_back(model_mem[a]);
    @(negedge clk);
  endtask

  task automatic drive_read16(input logic [7:0] a);
    @(negedge clk);
    cwe16 = 1'b0; ca16 = a;
    exp_q.push_back((a < 8'd16) ? model16[a[3:0]] : 8'h00);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ext_write = 0; ext_dump = 0; cpu_we = 0;
    data_in = 0; addr_in = 0; cpu_addr = 0; cpu_wdata = 0;
    w16 = 0; dp16 = 0; cwe16 = 0; d16 = 0; a16 = 0; ca16 = 0; cwd16 = 0;
    repeat (3) @(negedge clk);
    checks++; if (fsm_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, ST_IDLE); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", cpu_stall); end
    checks++; if (io_oeb !== 8'hFF) begin errors++; $display("FAIL reset_oeb: got %h expected ff", io_oeb); end
    checks++; if (mem_out !== 8'h00 || mem_strb !== 1'b0) begin errors++; $display("FAIL reset_dump_out: got %h/%b expected 00/0", mem_out, mem_strb); end
    checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", cpu_rdata); end
    checks++; if (addr_err !== 1'b0 || parity_err !== 1'b0) begin errors++; $display("FAIL reset_errs: got %b%b expected 00", addr_err, parity_err); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_core_rw;
    logic [7:0] e, a;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      cpu_we = 1'b1; cpu_addr = i[7:0]; cpu_wdata = i[7:0];
      model_mem[i] = i[7:0];
    end
    @(negedge clk); cpu_we = 1'b0;
    for (int k = 0; k < 10; k++) begin
      a = 8'($urandom_range(0, 255));
      drive_read(a);
      e = exp_q.pop_front();
      checks++; if (cpu_rdata !== e) begin errors++; $display("FAIL core_read[%h]: got %h expected %h", a, cpu_rdata, e); end
    end
    // same-cycle write and read of one address returns the old word
    @(negedge clk);
    cpu_addr = 8'h40; cpu_we = 1'b1; cpu_wdata = 8'hEE;
    exp_q.push_back(model_mem[8'h40]);
    @(negedge clk);
    cpu_we = 1'b0; model_mem[8'h40] = 8'hEE;
    e = exp_q.pop_front();
    checks++; if (cpu_rdata !== e) begin errors++; $display("FAIL same_cycle_old: got %h expected %h", cpu_rdata, e); end
    drive_read(8'h40);
    e = exp_q.pop_front();
    checks++; if (cpu_rdata !== e) begin errors++; $display("FAIL same_cycle_new: got %h expected %h", cpu_rdata, e); end
  endtask

  task automatic test_dump;
    logic [7:0] e, cur;
    logic prev_strb;
    int toggles, hold, cyc, oeb_bad, stall_bad, steady_bad, load_seen, not_idle;
    bit done;
    toggles = 0; hold = 0; cyc = 0; oeb_bad = 0; stall_bad = 0; steady_bad = 0;
    load_seen = 0; not_idle = 0; done = 0; cur = 0;
    for (int i = 0; i < 256; i++) exp_q.push_back(model_mem[i]);
    @(negedge clk);
    checks++; if (mem_out !== 8'h00) begin errors++; $display("FAIL idle_mem_out: got %h expected 00", mem_out); end
    prev_strb = mem_strb;
    ext_dump = 1'b1;
    while (!done && cyc < 1500) begin
      @(negedge clk); cyc++;
      if (cyc == 2) ext_dump = 1'b0;
      if (cyc == 100) begin ext_write = 1'b1; data_in = 8'h77; addr_in = 8'h20; end
      if (cyc == 103) ext_write = 1'b0;
      if (cyc == 200) ext_dump = 1'b1;
      if (cyc == 203) ext_dump = 1'b0;
      if (fsm_state == ST_LOAD) load_seen++;
      if (mem_strb !== prev_strb) begin
        if (toggles > 0) begin
          checks++; if (hold !== 4) begin errors++; $display("FAIL dump_hold[%0d]: got %0d expected 4", toggles - 1, hold); end
        end
        toggles++; prev_strb = mem_strb; hold = 1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx; cur = e;
        checks++; if (mem_out !== e) begin errors++; $display("FAIL dump_word[%0d]: got %h expected %h", toggles - 1, mem_out, e); end
      end else if (fsm_state == ST_DUMP) begin
        hold++;
        if (mem_out !== cur) steady_bad++;
      end
      if (fsm_state == ST_DUMP && io_oeb !== 8'h00) oeb_bad++;
      if (fsm_state == ST_DUMP && cpu_stall !== 1'b1) stall_bad++;
      if (toggles > 0 && fsm_state == ST_IDLE) done = 1;
    end
    checks++; if (!done) begin errors++; $display("FAIL dump_timeout: got %0d cycles expected completion", cyc); end
    checks++; if (toggles !== 256) begin errors++; $display("FAIL dump_toggles: got %0d expected 256", toggles); end
    checks++; if (hold !== 4) begin errors++; $display("FAIL dump_last_hold: got %0d expected 4", hold); end
    checks++; if (oeb_bad + stall_bad + steady_bad !== 0) begin errors++; $display("FAIL dump_levels: got oeb=%0d stall=%0d steady=%0d bad cycles expected 0", oeb_bad, stall_bad, steady_bad); end
    checks++; if (load_seen !== 0) begin errors++; $display("FAIL dump_ignores_write: got %0d load cycles expected 0", load_seen); end
    checks++; if (io_oeb !== 8'hFF || mem_out !== 8'h00 || cpu_stall !== 1'b0) begin errors++; $display("FAIL dump_end: got oeb=%h out=%h stall=%b expected ff/00/0", io_oeb, mem_out, cpu_stall); end
    exp_q.delete();
    repeat (20) begin @(negedge clk); if (fsm_state !== ST_IDLE) not_idle++; end
    checks++; if (not_idle !== 0) begin errors++; $display("FAIL dump_not_queued: got %0d busy cycles expected 0", not_idle); end
    drive_read(8'h20);
    e = exp_q.pop_front();
    checks++; if (cpu_rdata !== e) begin errors++; $display("FAIL dump_no_load: got %h expected %h", cpu_rdata, e); end
  endtask

  task automatic test_pad_load;
    logic [7:0] e;
    int stall_cnt;
    stall_cnt = 0;
    @(negedge clk);
    data_in = 8'hA5; addr_in = 8'h10; ext_write = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 1) ext_write = 1'b0;
      if (cpu_stall === 1'b1) stall_cnt++;
    end
    model_mem[8'h10] = 8'hA5;
    checks++; if (stall_cnt !== 1) begin errors++; $display("FAIL load_stall_cycles: got %0d expected 1", stall_cnt); end
    drive_read(8'h10);
    e = exp_q.pop_front();
    checks++; if (cpu_rdata !== e) begin errors++; $display("FAIL load_readback: got %h expected %h", cpu_rdata, e); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL load_addr_err: got %b expected 0", addr_err); end
  endtask

  task automatic test_collision;
    logic [7:0] e;
    int stall_cnt, dump_seen;
    stall_cnt = 0; dump_seen = 0;
    @(negedge clk);
    data_in = 8'h5A; addr_in = 8'h30; cpu_addr = 8'h31; cpu_wdata = 8'h3C;
    ext_write = 1'b1; ext_dump = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 1) begin ext_write = 1'b0; ext_dump = 1'b0; end
      if (fsm_state == ST_DUMP) dump_seen++;
      if (cpu_stall === 1'b1) stall_cnt++;
      cpu_we = (cpu_stall === 1'b1);
    end
    cpu_we = 1'b0;
    model_mem[8'h30] = 8'h5A;
    checks++; if (dump_seen !== 0) begin errors++; $display("FAIL collision_dump: got %0d dump cycles expected 0", dump_seen); end
    checks++; if (stall_cnt !== 1) begin errors++; $display("FAIL collision_stall: got %0d expected 1", stall_cnt); end
    drive_read(8'h30);
    e = exp_q.pop_front();
    checks++; if (cpu_rdata !== e) begin errors++; $display("FAIL collision_load: got %h expected %h", cpu_rdata, e); end
    drive_read(8'h31);
    e = exp_q.pop_front();
    checks++; if (cpu_rdata !== e) begin errors++; $display("FAIL stalled_write_dropped: got %h expected %h", cpu_rdata, e); end
  endtask

  task automatic test_reset_abort;
    logic [7:0] e;
    logic prev_strb;
    int toggles, cyc;
    // abort a load while it owns the array
    @(negedge clk);
    data_in = 8'hC3; addr_in = 8'h50; ext_write = 1'b1;
    cyc = 0;
    while (cpu_stall !== 1'b1 && cyc < 10) begin
      @(negedge clk); cyc++;
      if (cyc == 2) ext_write = 1'b0;
    end
    ext_write = 1'b0;
    checks++; if (cyc >= 10) begin errors++; $display("FAIL abort_load_start: got no stall expected stall"); end
    rst_n = 1'b0; #1;
    checks++; if (fsm_state !== ST_IDLE || cpu_stall !== 1'b0) begin errors++; $display("FAIL abort_load_reset: got %0d/%b expected IDLE/0", fsm_state, cpu_stall); end
    @(negedge clk); rst_n = 1'b1;
    drive_read(8'h50);
    e = exp_q.pop_front();
    checks++; if (cpu_rdata !== e) begin errors++; $display("FAIL abort_load_no_write: got %h expected %h", cpu_rdata, e); end
    // abort a dump while word 5 is on the pads
    @(negedge clk);
    prev_strb = mem_strb; ext_dump = 1'b1; toggles = 0; cyc = 0;
    while (toggles < 6 && cyc < 100) begin
      @(negedge clk); cyc++;
      if (cyc == 2) ext_dump = 1'b0;
      if (mem_strb !== prev_strb) begin toggles++; prev_strb = mem_strb; end
    end
    ext_dump = 1'b0;
    checks++; if (toggles !== 6 || mem_out !== model_mem[5]) begin errors++; $display("FAIL abort_dump_word5: got toggles=%0d out=%h expected 6/%h", toggles, mem_out, model_mem[5]); end
    #2 rst_n = 1'b0; #1;
    checks++; if (io_oeb !== 8'hFF || mem_out !== 8'h00) begin errors++; $display("FAIL abort_dump_pads: got oeb=%h out=%h expected ff/00", io_oeb, mem_out); end
    checks++; if (cpu_stall !== 1'b0 || mem_strb !== 1'b0 || cpu_rdata !== 8'h00) begin errors++; $display("FAIL abort_dump_outs: got %b%b/%h expected 00/00", cpu_stall, mem_strb, cpu_rdata); end
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (fsm_state !== ST_IDLE) begin errors++; $display("FAIL abort_dump_idle: got %0d expected %0d", fsm_state, ST_IDLE); end
    for (int i = 0; i < 10; i++) begin
      drive_read(8'(i * 9));
      e = exp_q.pop_front();
      checks++; if (cpu_rdata !== e) begin errors++; $display("FAIL mem_retained[%h]: got %h expected %h", 8'(i * 9), cpu_rdata, e); end
    end
  endtask

  task automatic pad_load16(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    d16 = d; a16 = a; w16 = 1'b1;
    repeat (2) @(negedge clk);
    w16 = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_addr_err;
    logic [7:0] e;
    @(negedge clk); cwe16 = 1'b1; ca16 = 8'h00; cwd16 = 8'h11; model16[0] = 8'h11;
    @(negedge clk); ca16 = 8'h05; cwd16 = 8'h55; model16[5] = 8'h55;
    @(negedge clk); ca16 = 8'h03; cwd16 = 8'h33; model16[3] = 8'h33;
    @(negedge clk); cwe16 = 1'b0;
    checks++; if (ae16 !== 1'b0) begin errors++; $display("FAIL addr_err_initial: got %b expected 0", ae16); end
    pad_load16(8'h20, 8'h99);
    checks++; if (ae16 !== 1'b1) begin errors++; $display("FAIL addr_err_set: got %b expected 1", ae16); end
    drive_read16(8'h00);
    e = exp_q.pop_front();
    checks++; if (rd16 !== e) begin errors++; $display("FAIL oob_load_no_write: got %h expected %h", rd16, e); end
    pad_load16(8'h03, 8'h44); model16[3] = 8'h44;
    checks++; if (ae16 !== 1'b1) begin errors++; $display("FAIL addr_err_sticky: got %b expected 1", ae16); end
    drive_read16(8'h03);
    e = exp_q.pop_front();
    checks++; if (rd16 !== e) begin errors++; $display("FAIL valid_load16: got %h expected %h", rd16, e); end
    @(negedge clk); cwe16 = 1'b1; ca16 = 8'h25; cwd16 = 8'h77;
    @(negedge clk); cwe16 = 1'b0;
    drive_read16(8'h05);
    e = exp_q.pop_front();
    checks++; if (rd16 !== e) begin errors++; $display("FAIL oob_core_write: got %h expected %h", rd16, e); end
    drive_read16(8'h25);
    e = exp_q.pop_front();
    checks++; if (rd16 !== e) begin errors++; $display("FAIL oob_core_read: got %h expected %h", rd16, e); end
  endtask

  task automatic test_parity;
`ifdef SPM_MEM_PARITY_EN
    @(negedge clk);
    dut.mem[4] = dut.mem[4] ^ 9'h001;
    cpu_we = 1'b0; cpu_addr = 8'h04;
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL parity_before: got %b expected 0", parity_err); end
    @(negedge clk);
    checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL parity_flag: got %b expected 1", parity_err); end
`else
    @(negedge clk);
    checks++; if (parity_err !== 1'b0 || pe16 !== 1'b0) begin errors++; $display("FAIL parity_tied: got %b%b expected 00", parity_err, pe16); end
`endif
  endtask

  initial begin
    test_reset();
    test_core_rw();
    test_dump();
    test_pad_load();
    test_collision();
    test_reset_abort();
    test_addr_err();
    test_parity();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
